// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : store_buffer
//  Purpose  : Word-granular store FIFO between the CPU store path and the
//             data memory. Drains one entry per cycle and forwards buffered
//             data to loads that hit a pending store (youngest match wins).
//  Revision : 1.0  initial release
// ============================================================================
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       st_valid,
  output logic                       st_ready,
  input  logic [31:0]                st_pc,
  input  logic [AW-1:0]              st_addr,
  input  logic [DW-1:0]              st_data,
  input  logic                       drain_en,
  output logic                       dm_we,
  output logic [31:0]                dm_pc,
  output logic [AW-1:0]              dm_addr,
  output logic [DW-1:0]              dm_data,
  input  logic [AW-1:0]              ld_addr,
  output logic                       ld_hit,
  output logic [DW-1:0]              ld_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  // Entry storage; payloads need no reset because the valid bits gate them.
  logic [31:0]      entry_pc   [DEPTH];
  logic [AW-1:0]    entry_addr [DEPTH];
  logic [DW-1:0]    entry_data [DEPTH];
  logic [DEPTH-1:0] entry_valid;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic [PW-1:0] slot;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign st_ready = !full;
  assign push     = st_valid && st_ready;
  // Suppress the write strobe while reset is asserted so that stores being
  // discarded by a mid-operation reset never reach the memory.
  assign pop      = !empty && drain_en && reset;
  assign dm_we    = pop;

  // Head entry presentation; zero when nothing is buffered.
  always_comb begin
    dm_pc   = '0;
    dm_addr = '0;
    dm_data = '0;
    if (!empty) begin
      dm_pc   = entry_pc[rd_ptr];
      dm_addr = entry_addr[rd_ptr];
      dm_data = entry_data[rd_ptr];
    end
  end

  // Pointer, occupancy and valid-bit bookkeeping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      entry_valid <= '0;
    end else begin
      if (pop) begin
        rd_ptr              <= rd_ptr + PW'(1);
        entry_valid[rd_ptr] <= 1'b0;
      end
      if (push) begin
        wr_ptr              <= wr_ptr + PW'(1);
        entry_valid[wr_ptr] <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload write on an accepted store.
  always_ff @(posedge clk) begin
    if (push) begin
      entry_pc[wr_ptr]   <= st_pc;
      entry_addr[wr_ptr] <= st_addr;
      entry_data[wr_ptr] <= st_data;
    end
  end

  // Load forwarding: walk entries oldest to youngest so the youngest
  // matching word overrides older ones. Byte offset is ignored.
  always_comb begin
    ld_hit  = 1'b0;
    ld_data = '0;
    slot    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = rd_ptr + PW'(i);
      if (entry_valid[slot] && (ld_addr[AW-1:2] == entry_addr[slot][AW-1:2])) begin
        ld_hit  = 1'b1;
        ld_data = entry_data[slot];
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Word-granular store buffer between the CPU's store path and the data memory; the data memory is word-addressed with a single write-enable.
- Accepts stores from the execute side into a FIFO.
- Drains one entry per cycle into the data memory's write port.
- Forwards buffered data to loads that hit a pending store, so loads see program-order data while writes are deferred.

Parameters:
- DEPTH, 4, number of entries; power of two, ≥2.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low; reset==0 at a rising edge clears the block.
- st_valid  input  1  store request.
- st_ready  output  1  buffer can accept a store this cycle.
- st_pc  input  32  PC of the store, carried to the memory for trace.
- st_addr  input  AW  byte address of the store.
- st_data  input  DW  store word.
- drain_en  input  1  memory port is available to accept a write this cycle.
- dm_we  output  1  write strobe to the data memory.
- dm_pc  output  32  PC of the head entry.
- dm_addr  output  AW  address of the head entry.
- dm_data  output  DW  data of the head entry.
- ld_addr  input  AW  load byte address (combinational lookup).
- ld_hit  output  1  a buffered store matches ld_addr.
- ld_data  output  DW  forwarded word; valid when ld_hit==1.
- count  output  clog2(DEPTH+1)  number of occupied entries.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.

Behaviour:
- Storage: circular FIFO with DEPTH entries. Each entry holds {pc, addr, data}. Pointers wr_ptr and rd_ptr are clog2(DEPTH) bits and wrap naturally. count is a separate register.
- Reset (reset==0 at posedge):
  - wr_ptr=0, rd_ptr=0, count=0.
  - Entry valid bits cleared. Entry payloads are don't-care.
  - Outputs after reset: empty=1, full=0, count=0, st_ready=1, dm_we=0, ld_hit=0, ld_data=0.
  - A reset mid-operation discards all pending stores; none are written to memory.
  - Reset has priority over push and pop in the same cycle.
- Push:
  - push = st_valid & st_ready.
  - st_ready = !full. There is no same-cycle bypass of a pop into a full buffer.
  - On push, the entry is written at wr_ptr and wr_ptr advances.
  - If st_valid is asserted while full, the request is not taken. Upstream must hold it.
- Pop:
  - pop = dm_we = !empty & drain_en. This is combinational.
  - dm_pc, dm_addr and dm_data always present the head entry. They are 0 when empty.
  - The memory commits the write at the same rising edge at which rd_ptr advances.
- Latency: a store pushed at edge N is at the head no earlier than after edge N. It can be written at edge N+1 at the earliest.
- Push and pop in the same cycle: both occur and count is unchanged. This is legal at any count from 1 to DEPTH-1. At count==DEPTH, push is blocked.
- Count update: count += push - pop. It never underflows or overflows.
- Load forwarding:
  - Combinational. A match is ld_addr[AW-1:2] == entry.addr[AW-1:2] for any valid entry; the byte offset is ignored.
  - When several entries match, the youngest (closest to wr_ptr) wins.
  - The head entry being drained in the current cycle still forwards. The memory read port shows the old value until the edge.
  - A store being pushed in the current cycle is NOT visible to ld_* until the next cycle. The pipeline must not issue a dependent load in that same cycle.
  - When there is no match: ld_hit=0 and ld_data=0.
- Alignment: addresses are passed through unchanged. The buffer neither checks nor corrects misalignment.

Test Plan:
- Reset then idle:
  - Stimulus: reset=0 for 2 cycles, then 1.
  - Required: count=0, empty=1, st_ready=1, dm_we=0 and ld_hit=0 for 5 cycles.
- Fill and block:
  - Stimulus: drain_en=0; push stores to 0x0, 0x4, 0x8, 0xC with data 0x11 to 0x44.
  - Required: full=1 and st_ready=0 after the 4th push. A 5th push (0x10, 0x55) is held and not accepted. Then drain_en=1.
  - Required: dm_we=1 for 4 consecutive cycles with addr/data 0x0/0x11, 0x4/0x22, 0x8/0x33, 0xC/0x44 in that order. empty=1 afterwards.
- Forwarding, youngest wins:
  - Stimulus: drain_en=0; push 0x100 ← 0xAAAA, then 0x100 ← 0xBBBB.
  - Required: with ld_addr=0x102, ld_hit=1 and ld_data=0xBBBB. With ld_addr=0x104, ld_hit=0 and ld_data=0.
- Simultaneous push and pop:
  - Stimulus: start with count=2; push 0x20 ← 0x7 while drain_en=1.
  - Required: count stays 2. The head is written, and the tail is 0x20/0x7. Wrap-around is correct after 8 such cycles: the order is preserved and no entry is lost or duplicated.
- Same-cycle push not forwarded:
  - Stimulus: empty buffer; push 0x40 ← 0x9 with ld_addr=0x40 in the same cycle.
  - Required: ld_hit=0 that cycle, and ld_hit=1 with ld_data=0x9 in the next cycle.
- Reset mid-operation:
  - Stimulus: count=3; reset=0 for one edge while drain_en=1 and st_valid=1.
  - Required: count=0 after the edge, no further dm_we for the discarded entries, and st_ready=1.
